// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, WIDTH data bits MSB first, optional even parity, stop bit.
// Latency: word visible WIDTH+1+PARITY_EN edges after the start-bit edge; error pulses last one cycle.
// Backpressure: one-word holding register; a good frame arriving while it is full and not draining is dropped (overrun).
module serial_frame_rx #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             par;
    logic             parity_bad;
    logic             can_load;

    // Even parity over data plus parity bit must be zero; ignored when no parity bit is sent.
    assign parity_bad = (PARITY_EN != 0) && ((^shreg) ^ par);
    // Holding register accepts a new word if empty or being drained on this same edge.
    assign can_load   = !out_valid || out_ready;

    // Frame FSM, shift register, holding register and one-cycle error pulses.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            out        <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (in) begin
                        state <= DATA;
                        cnt   <= CW'(WIDTH - 1);
                        shreg <= '0;
                    end
                end
                DATA: begin
                    shreg <= {shreg[WIDTH-2:0], in};
                    if (cnt == '0) begin
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PARITY: begin
                    par   <= in;
                    state <= STOP;
                end
                STOP: begin
                    // A start bit may follow immediately, so always return to IDLE.
                    state <= IDLE;
                    if (in) begin
                        frame_err <= 1'b1;
                    end else if (parity_bad) begin
                        parity_err <= 1'b1;
                    end else if (can_load) begin
                        out       <= shreg;
                        out_valid <= 1'b1;
                    end else begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
